// File: rtl/decode_sequencer.sv
// decode_sequencer: frame-level controller for the radix-4 decoder front end.
// It takes 16-bit words over a valid/ready handshake and holds each one on the
// extractor input. It enables the extractor for exactly four cycles per word,
// follows with the ACS enable one cycle later, and runs traceback once the
// last word of the frame has been extracted.
// Optional feature macro: SEQ_PREFETCH_EN. When defined, the next word can be
// accepted in the last extract cycle of the current word, so extraction runs
// without a bubble between words.
module decode_sequencer #(
  parameter int FRAME_WORDS = 8,
  parameter int TB_LEN      = 32,
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1,
  localparam int TBW = (TB_LEN > 1) ? $clog2(TB_LEN) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  input  logic [15:0]    i_data,
  output logic           o_ready,
  output logic [15:0]    o_data,
  output logic           o_en_extract,
  output logic [1:0]     o_sym_idx,
  output logic           o_en_acs,
  output logic           o_tb_en,
  output logic [WCW-1:0] o_word_cnt,
  output logic           o_busy,
  output logic           o_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXTRACT,
    FLUSH,
    TRACEBACK,
    DONE
  } state_t;

  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);
  localparam logic [TBW-1:0] LAST_TB   = TBW'(TB_LEN - 1);

  state_t         state;
  logic [TBW-1:0] tb_cnt;
  logic           accept;

  // Ready is combinational so it can be held low during reset and raised in
  // the very first cycle after release.
  always_comb begin
    o_ready = 1'b0;
    if (rst) begin
      case (state)
        IDLE, LOAD: o_ready = 1'b1;
`ifdef SEQ_PREFETCH_EN
        EXTRACT:    o_ready = (o_sym_idx == 2'd3) && (o_word_cnt != LAST_WORD);
`endif
        default:    o_ready = 1'b0;
      endcase
    end
  end

  assign accept = i_valid && o_ready;

  // Frame FSM with all outputs registered; enables are pulsed by default and
  // only re-asserted by the state that owns them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      tb_cnt       <= '0;
      o_data       <= '0;
      o_en_extract <= 1'b0;
      o_sym_idx    <= 2'd0;
      o_en_acs     <= 1'b0;
      o_tb_en      <= 1'b0;
      o_word_cnt   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_en_acs     <= o_en_extract;
      o_en_extract <= 1'b0;
      o_tb_en      <= 1'b0;
      o_done       <= 1'b0;
      if (accept) begin
        o_data <= i_data;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            o_word_cnt   <= '0;
            o_sym_idx    <= 2'd0;
            o_en_extract <= 1'b1;
            o_busy       <= 1'b1;
            state        <= EXTRACT;
          end
        end
        LOAD: begin
          if (accept) begin
            o_sym_idx    <= 2'd0;
            o_en_extract <= 1'b1;
            state        <= EXTRACT;
          end
        end
        EXTRACT: begin
          if (o_sym_idx != 2'd3) begin
            o_sym_idx    <= o_sym_idx + 2'd1;
            o_en_extract <= 1'b1;
          end else if (o_word_cnt == LAST_WORD) begin
            state <= FLUSH;
          end else begin
            o_word_cnt <= o_word_cnt + WCW'(1);
            if (accept) begin
              o_sym_idx    <= 2'd0;
              o_en_extract <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        FLUSH: begin
          tb_cnt  <= '0;
          o_tb_en <= 1'b1;
          state   <= TRACEBACK;
        end
        TRACEBACK: begin
          if (tb_cnt == LAST_TB) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            tb_cnt  <= tb_cnt + TBW'(1);
            o_tb_en <= 1'b1;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Testbench for decode_sequencer. Two instances: a two-word frame with a short
// traceback, and a single-word frame. Expected outputs come from a frame
// schedule model: each accept at cycle a gives extract cycles a+1..a+4, and the
// last word's accept fixes flush, traceback and done cycles by arithmetic.
module tb_decode_sequencer;

  localparam int FW_A = 2;
  localparam int TB_A = 4;
  localparam int FW_B = 1;
  localparam int TB_B = 3;
`ifdef SEQ_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  typedef struct packed {
    logic        ready;
    logic [15:0] data;
    logic        ext;
    logic [1:0]  sym;
    logic        acs;
    logic        tb;
    logic [3:0]  wc;
    logic        busy;
    logic        done;
  } outs_t;

  typedef struct {
    bit          frame;
    bit          any;
    int          k;
    int          acc;
    bit          prev_ext;
    logic [15:0] data;
  } model_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic [15:0] data_a = '0;
  logic [15:0] data_b = '0;

  logic        ready_a, ext_a, acs_a, tb_a, busy_a, done_a;
  logic [15:0] q_a;
  logic [1:0]  sym_a;
  logic [0:0]  wc_a;
  logic        ready_b, ext_b, acs_b, tb_b, busy_b, done_b;
  logic [15:0] q_b;
  logic [1:0]  sym_b;
  logic [0:0]  wc_b;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  model_t ma, mb;

  decode_sequencer #(.FRAME_WORDS(FW_A), .TB_LEN(TB_A)) dut_a (
    .clk(clk), .rst(rst), .i_valid(valid_a), .i_data(data_a),
    .o_ready(ready_a), .o_data(q_a), .o_en_extract(ext_a), .o_sym_idx(sym_a),
    .o_en_acs(acs_a), .o_tb_en(tb_a), .o_word_cnt(wc_a), .o_busy(busy_a),
    .o_done(done_a)
  );

  decode_sequencer #(.FRAME_WORDS(FW_B), .TB_LEN(TB_B)) dut_b (
    .clk(clk), .rst(rst), .i_valid(valid_b), .i_data(data_b),
    .o_ready(ready_b), .o_data(q_b), .o_en_extract(ext_b), .o_sym_idx(sym_b),
    .o_en_acs(acs_b), .o_tb_en(tb_b), .o_word_cnt(wc_b), .o_busy(busy_b),
    .o_done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic model_t model_reset();
    model_t m;
    m.frame = 1'b0; m.any = 1'b0; m.k = 0; m.acc = 0;
    m.prev_ext = 1'b0; m.data = 16'h0000;
    return m;
  endfunction

  // A frame is in progress until the done cycle of its last word has passed.
  function automatic bit active(model_t m, int fw, int tbl, int c);
    return m.frame && !(m.k == fw - 1 && c > m.acc + tbl + 6);
  endfunction

  function automatic bit ready_logic(model_t m, int fw, int tbl, int c);
    if (!active(m, fw, tbl, c)) return 1'b1;
    if (m.k < fw - 1) return (c >= m.acc + 5) || (PREFETCH && c == m.acc + 4);
    return 1'b0;
  endfunction

  function automatic outs_t predict(model_t m, int fw, int tbl, int c, logic rst_now);
    outs_t o;
    bit act = active(m, fw, tbl, c);
    bit last = (m.k == fw - 1);
    o.ready = rst_now && ready_logic(m, fw, tbl, c);
    o.data  = m.data;
    o.ext   = act && c >= m.acc + 1 && c <= m.acc + 4;
    o.sym   = !m.any ? 2'd0 : (o.ext ? 2'(c - m.acc - 1) : 2'd3);
    o.acs   = m.prev_ext;
    o.tb    = act && last && c >= m.acc + 6 && c <= m.acc + tbl + 5;
    o.wc    = !m.any ? 4'd0 : ((o.ext || !(m.k < fw - 1)) ? 4'(m.k) : 4'(m.k + 1));
    o.busy  = act;
    o.done  = act && last && c == m.acc + tbl + 6;
    return o;
  endfunction

  function automatic model_t advance(model_t m, int fw, int tbl, int c, logic v,
                                     logic [15:0] d, logic rst_next);
    model_t n = m;
    if (!rst_next) return model_reset();
    n.prev_ext = predict(m, fw, tbl, c, 1'b1).ext;
    if (v && ready_logic(m, fw, tbl, c)) begin
      if (!active(m, fw, tbl, c)) begin
        n.frame = 1'b1;
        n.k = 0;
      end else begin
        n.k = m.k + 1;
      end
      n.any  = 1'b1;
      n.acc  = c;
      n.data = d;
    end
    return n;
  endfunction

  function automatic outs_t obs_a();
    return '{ready: ready_a, data: q_a, ext: ext_a, sym: sym_a, acs: acs_a,
             tb: tb_a, wc: {3'b000, wc_a}, busy: busy_a, done: done_a};
  endfunction

  function automatic outs_t obs_b();
    return '{ready: ready_b, data: q_b, ext: ext_b, sym: sym_b, acs: acs_b,
             tb: tb_b, wc: {3'b000, wc_b}, busy: busy_b, done: done_b};
  endfunction

  task automatic test_reset();
    outs_t got, want;
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ma = model_reset();
    mb = model_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      got = obs_a(); want = predict(ma, FW_A, TB_A, cyc, rst);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL reset_a cyc=%0d got=%h want=%h", cyc, got, want);
      end
      got = obs_b(); want = predict(mb, FW_B, TB_B, cyc, rst);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL reset_b cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (i == 1) rst = 1'b1;
      ma = advance(ma, FW_A, TB_A, cyc, 1'b0, 16'h0000, rst);
      mb = advance(mb, FW_B, TB_B, cyc, 1'b0, 16'h0000, rst);
    end
  endtask

  task automatic test_two_words();
    logic [15:0] words [2];
    outs_t got, want;
    logic v;
    logic [15:0] d;
    int idx = 0;
    words[0] = 16'hA5C3;
    words[1] = 16'h1234;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      got = obs_a(); want = predict(ma, FW_A, TB_A, cyc, rst);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL two_words cyc=%0d got=%h want=%h", cyc, got, want);
      end
      v = (idx < 2);
      d = v ? words[idx] : 16'($urandom);
      valid_a = v; data_a = d;
      if (v && rst && ready_logic(ma, FW_A, TB_A, cyc)) idx++;
      ma = advance(ma, FW_A, TB_A, cyc, v, d, rst);
    end
  endtask

  task automatic test_stall();
    outs_t got, want;
    logic v;
    logic [15:0] d;
    int idx = 0;
    int t0 = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      got = obs_a(); want = predict(ma, FW_A, TB_A, cyc, rst);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL stall cyc=%0d got=%h want=%h", cyc, got, want);
      end
      v = (idx == 0) || (idx == 1 && cyc >= t0 + 15);
      d = 16'($urandom);
      valid_a = v; data_a = d;
      if (v && rst && ready_logic(ma, FW_A, TB_A, cyc)) begin
        if (idx == 0) t0 = cyc;
        idx++;
      end
      ma = advance(ma, FW_A, TB_A, cyc, v, d, rst);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] words [4];
    outs_t got, want;
    logic v;
    logic [15:0] d;
    int idx = 0;
    int hold = 0;
    bit fired = 1'b0;
    words[0] = 16'h1111; words[1] = 16'h2222;
    words[2] = 16'hF00F; words[3] = 16'h0FF0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      got = obs_a(); want = predict(ma, FW_A, TB_A, cyc, rst);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL mid_reset cyc=%0d got=%h want=%h", cyc, got, want);
      end
      if (!fired && ma.frame && ma.k == 1 && cyc == ma.acc + 2) begin
        rst = 1'b0; hold = 2; fired = 1'b1; idx = 2;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) rst = 1'b1;
      end
      v = (idx < 4) && rst && hold == 0;
      d = v ? words[idx] : 16'($urandom);
      valid_a = v; data_a = d;
      if (v && ready_logic(ma, FW_A, TB_A, cyc)) idx++;
      ma = advance(ma, FW_A, TB_A, cyc, v, d, rst);
    end
  endtask

  task automatic test_random_frames(int ncyc);
    outs_t got, want;
    logic v;
    logic [15:0] d;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      got = obs_a(); want = predict(ma, FW_A, TB_A, cyc, rst);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL random_frames cyc=%0d got=%h want=%h", cyc, got, want);
      end
      v = ($urandom_range(0, 3) != 0);
      d = 16'($urandom);
      valid_a = v; data_a = d;
      ma = advance(ma, FW_A, TB_A, cyc, v, d, rst);
    end
    valid_a = 1'b0;
  endtask

  task automatic test_single_word(int ncyc);
    outs_t got, want;
    logic v;
    logic [15:0] d;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      got = obs_b(); want = predict(mb, FW_B, TB_B, cyc, rst);
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL single_word cyc=%0d got=%h want=%h", cyc, got, want);
      end
      v = ($urandom_range(0, 2) != 0);
      d = 16'($urandom);
      valid_b = v; data_b = d;
      mb = advance(mb, FW_B, TB_B, cyc, v, d, rst);
    end
    valid_b = 1'b0;
  endtask

  // Run the scenarios in order and report a single summary.
  initial begin
    test_reset();
    test_two_words();
    test_stall();
    test_mid_reset();
    test_random_frames(400);
    test_single_word(150);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
